mod12_wrap_monitor: RTL and testbench
=====================================

// Module: mod12_wrap_monitor
// PURPOSE
//  Downstream observer of the mod-12 up/down counter: samples the counter's data_out
//  every clock, classifies each step, counts up/down wrap-arounds and queues notable
//  events (wrap, load jump, illegal value) in a small FIFO with a valid/ready handshake.
//  Sits beside the counter in the datapath and feeds a status/logging consumer.
// PARAMETERS
//  CNT_W   8   width of the up_wraps/dn_wraps counters (saturating)
//  DEPTH   4   event FIFO depth in entries; power of 2, >= 2
// PORTS
//  clock        in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  count_in     in   4      counter data_out, legal range 0..11
//  clear        in   1      synchronous clear of counters, flags, FIFO; re-arms tracker
//  up_wraps     out  CNT_W  number of 11->0 transitions seen
//  dn_wraps     out  CNT_W  number of 0->11 transitions seen
//  ev_valid     out  1      FIFO head entry valid
//  ev_ready     in   1      consumer accepts head when ev_valid && ev_ready
//  ev_code      out  2      head event: 0 WRAP_UP, 1 WRAP_DN, 2 JUMP, 3 ILLEGAL
//  ev_count     out  4      count_in value that caused the head event
//  ev_ovf       out  1      sticky: an event was dropped because FIFO was full
//  illegal_seen out  1      sticky: a count_in > 11 was sampled
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, FIFO empty, tracker in ARM, prev_q=0.
//  Tracker FSM: ARM -> TRACK on any legal sample (stores prev_q, no event);
//   ARM stays ARM on illegal sample (ILLEGAL event still pushed);
//   TRACK -> ARM on illegal sample or clear; otherwise TRACK.
//  Classification in TRACK, cur=count_in vs prev_q (mod-12 arithmetic):
//   cur>11 -> ILLEGAL; prev_q=11,cur=0 -> WRAP_UP; prev_q=0,cur=11 -> WRAP_DN;
//   cur=prev_q+1 or prev_q-1 (non-wrap) -> step, no event; cur=prev_q -> hold, no event;
//   any other legal cur -> JUMP. prev_q <= cur on every legal sample.
//  Latency: sample at edge N; counters updated and event written at edge N;
//   ev_valid visible after edge N (1 cycle). FIFO is show-ahead (head on ev_code/ev_count).
//  up_wraps/dn_wraps saturate at 2^CNT_W-1; never wrap.
//  FIFO: pop = ev_valid && ev_ready. Push when full without pop -> event dropped,
//   ev_ovf<=1, existing entries untouched. Push and pop same cycle when full -> both
//   occur, no drop. Empty pop is impossible (ev_valid=0). Order strictly FIFO.
//  illegal_seen, ev_ovf cleared only by reset or clear.
//  clear=1: same effect as reset at the next edge; overrides any push/pop/sample that
//   cycle (sample is discarded, tracker goes ARM).
//  ev_code/ev_count hold last head value when ev_valid=0 is don't-care; bench ignores.
//  Reset asserted mid-operation: immediate return to reset state, queued events lost.
// TESTING
//  1 reset, count_in 0,1..11,0, ev_ready=1 -> up_wraps=1, one event {WRAP_UP,0}, valid 1 cycle after 0 sampled
//  2 count_in 2,1,0,11 -> dn_wraps=1, single event {WRAP_DN,11}; no events for 2->1->0
//  3 count_in 3,9,9,10 -> one event {JUMP,9}; hold 9->9 and step 9->10 produce none
//  4 count_in 4,13,5,6 -> {ILLEGAL,13}, illegal_seen=1; 5 re-arms silently, 6 no event
//  5 ev_ready=0, 6 up-wraps -> 4 entries held, ev_ovf=1; drain gives 4 WRAP_UP in order, then ev_valid=0
//  6 CNT_W=2, 5 up-wraps -> up_wraps=3 (saturated); reset low mid-stream -> all outputs 0 asynchronously

Source files
------------

// File: rtl/mod12_wrap_monitor.sv
// Observer for a mod-12 up/down counter. Each sample is classified against
// the previous legal value; wraps are counted and notable events are queued
// in a small show-ahead FIFO drained through a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// ARM   | no trusted previous value; the next legal sample is stored only
// TRACK | prev_q holds the last legal sample; steps are classified
module mod12_wrap_monitor #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       count_in,
    input  logic             clear,
    output logic [CNT_W-1:0] up_wraps,
    output logic [CNT_W-1:0] dn_wraps,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [1:0]       ev_code,
    output logic [3:0]       ev_count,
    output logic             ev_ovf,
    output logic             illegal_seen
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    FULL_LVL = (AW + 1)'(DEPTH);

    localparam logic [1:0] EV_WRAP_UP = 2'd0;
    localparam logic [1:0] EV_WRAP_DN = 2'd1;
    localparam logic [1:0] EV_JUMP    = 2'd2;
    localparam logic [1:0] EV_ILLEGAL = 2'd3;

    typedef enum logic {
        ARM   = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      prev_q;

    logic            legal;
    logic            ev_push;
    logic [1:0]      ev_code_new;
    logic            inc_up;
    logic            inc_dn;

    logic [1:0]      mem_code  [DEPTH];
    logic [3:0]      mem_count [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fill;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    assign legal    = (count_in <= 4'd11);
    assign full     = (fill == FULL_LVL);
    assign ev_valid = (fill != '0);
    assign pop      = ev_valid && ev_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = ev_push && (!full || pop);
    assign drop     = ev_push && full && !pop;
    assign ev_code  = mem_code[rd_ptr];
    assign ev_count = mem_count[rd_ptr];

    // Tracker state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ARM;
        end else if (clear) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and step classification of the current sample.
    always_comb begin
        state_d     = state_q;
        ev_push     = 1'b0;
        ev_code_new = EV_JUMP;
        inc_up      = 1'b0;
        inc_dn      = 1'b0;
        if (!legal) begin
            state_d     = ARM;
            ev_push     = 1'b1;
            ev_code_new = EV_ILLEGAL;
        end else begin
            state_d = TRACK;
            if (state_q == TRACK) begin
                if (prev_q == 4'd11 && count_in == 4'd0) begin
                    ev_push     = 1'b1;
                    ev_code_new = EV_WRAP_UP;
                    inc_up      = 1'b1;
                end else if (prev_q == 4'd0 && count_in == 4'd11) begin
                    ev_push     = 1'b1;
                    ev_code_new = EV_WRAP_DN;
                    inc_dn      = 1'b1;
                end else if (count_in == prev_q ||
                             count_in == prev_q + 4'd1 ||
                             count_in + 4'd1 == prev_q) begin
                    ev_push = 1'b0;
                end else begin
                    ev_push     = 1'b1;
                    ev_code_new = EV_JUMP;
                end
            end
        end
    end

    // Previous-sample register, saturating wrap counters and sticky flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q       <= 4'd0;
            up_wraps     <= '0;
            dn_wraps     <= '0;
            ev_ovf       <= 1'b0;
            illegal_seen <= 1'b0;
        end else if (clear) begin
            prev_q       <= 4'd0;
            up_wraps     <= '0;
            dn_wraps     <= '0;
            ev_ovf       <= 1'b0;
            illegal_seen <= 1'b0;
        end else begin
            if (legal) begin
                prev_q <= count_in;
            end else begin
                illegal_seen <= 1'b1;
            end
            if (inc_up && up_wraps != '1) begin
                up_wraps <= up_wraps + CNT_W'(1);
            end
            if (inc_dn && dn_wraps != '1) begin
                dn_wraps <= dn_wraps + CNT_W'(1);
            end
            if (drop) begin
                ev_ovf <= 1'b1;
            end
        end
    end

    // Event FIFO: storage, pointers and fill level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_code[i]  <= 2'd0;
                mem_count[i] <= 4'd0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_code[i]  <= 2'd0;
                mem_count[i] <= 4'd0;
            end
        end else begin
            if (push_ok) begin
                mem_code[wr_ptr]  <= ev_code_new;
                mem_count[wr_ptr] <= count_in;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                fill <= fill + (AW + 1)'(1);
            end else if (pop && !push_ok) begin
                fill <= fill - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_mod12_wrap_monitor.sv
// Bench for mod12_wrap_monitor: a reference model pushes expected events into
// a queue as each sample is driven; entries are popped and compared when the
// DUT hands its FIFO head to the consumer.
module tb_mod12_wrap_monitor;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       clear;
    logic       ev_ready;

    logic [7:0] up_wraps, dn_wraps;
    logic       ev_valid, ev_ovf, illegal_seen;
    logic [1:0] ev_code;
    logic [3:0] ev_count;

    logic [1:0] s_up_wraps, s_dn_wraps;
    logic       s_ev_valid, s_ev_ovf, s_illegal_seen;
    logic [1:0] s_ev_code;
    logic [3:0] s_ev_count;

    int checks = 0;
    int errors = 0;

    // model state
    int m_up, m_dn;
    bit m_ovf, m_ill, m_track;
    int m_prev;
    int exp_q[$];   // code*16 + count

    always #5 clock = ~clock;

    mod12_wrap_monitor #(.CNT_W(8), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .count_in(count_in), .clear(clear),
        .up_wraps(up_wraps), .dn_wraps(dn_wraps), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_code(ev_code), .ev_count(ev_count),
        .ev_ovf(ev_ovf), .illegal_seen(illegal_seen)
    );

    mod12_wrap_monitor #(.CNT_W(2), .DEPTH(DEPTH)) dut_sat (
        .clock(clock), .reset(reset), .count_in(count_in), .clear(clear),
        .up_wraps(s_up_wraps), .dn_wraps(s_dn_wraps), .ev_valid(s_ev_valid),
        .ev_ready(ev_ready), .ev_code(s_ev_code), .ev_count(s_ev_count),
        .ev_ovf(s_ev_ovf), .illegal_seen(s_illegal_seen)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic model_reset();
        m_up = 0; m_dn = 0; m_ovf = 0; m_ill = 0; m_track = 0; m_prev = 0;
        exp_q.delete();
    endtask

    // Called at posedge+1; drives one sample and returns at the next posedge+1.
    task automatic step(input int c, input bit rdy, input bit clr);
        int ev;
        int head;
        count_in = 4'(c);
        ev_ready = rdy;
        clear    = clr;
        check("ev_valid", int'(ev_valid), int'(exp_q.size() != 0));
        if (clr) begin
            model_reset();
        end else begin
            if (ev_valid && rdy && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                check("ev_code", int'(ev_code), head / 16);
                check("ev_count", int'(ev_count), head % 16);
            end
            ev = -1;
            if (c > 11) begin
                ev = 3;
                m_ill = 1;
                m_track = 0;
            end else begin
                if (m_track) begin
                    if (m_prev == 11 && c == 0) begin
                        ev = 0;
                        if (m_up < 255) m_up++;
                    end else if (m_prev == 0 && c == 11) begin
                        ev = 1;
                        if (m_dn < 255) m_dn++;
                    end else if (c != m_prev && c != m_prev + 1 && c != m_prev - 1) begin
                        ev = 2;
                    end
                end
                m_track = 1;
                m_prev  = c;
            end
            if (ev >= 0) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(ev * 16 + c);
                else m_ovf = 1;
            end
        end
        @(posedge clock);
        #1;
        check("up_wraps", int'(up_wraps), m_up);
        check("dn_wraps", int'(dn_wraps), m_dn);
        check("ev_ovf", int'(ev_ovf), int'(m_ovf));
        check("illegal_seen", int'(illegal_seen), int'(m_ill));
        check("sat_up_wraps", int'(s_up_wraps), sat3(m_up));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_up"}, int'(up_wraps), 0);
        check({tag, "_dn"}, int'(dn_wraps), 0);
        check({tag, "_valid"}, int'(ev_valid), 0);
        check({tag, "_code"}, int'(ev_code), 0);
        check({tag, "_count"}, int'(ev_count), 0);
        check({tag, "_ovf"}, int'(ev_ovf), 0);
        check({tag, "_ill"}, int'(illegal_seen), 0);
        check({tag, "_sat_up"}, int'(s_up_wraps), 0);
        check({tag, "_sat_valid"}, int'(s_ev_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; count_in = 4'd0; clear = 1'b0; ev_ready = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // 1: full up count 0..11 then wrap to 0
        for (int i = 0; i <= 11; i++) step(i, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0);
        check("t1_valid_after_wrap", int'(ev_valid), 1);
        step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0);

        // 2: down wrap
        step(0, 1'b1, 1'b1);
        step(2, 1'b1, 1'b0); step(1, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0); step(11, 1'b1, 1'b0);
        step(11, 1'b1, 1'b0); step(11, 1'b1, 1'b0);

        // 3: jump, hold, step
        step(0, 1'b1, 1'b1);
        step(3, 1'b1, 1'b0); step(9, 1'b1, 1'b0);
        step(9, 1'b1, 1'b0); step(10, 1'b1, 1'b0);
        step(10, 1'b1, 1'b0); step(10, 1'b1, 1'b0);

        // 4: illegal value then silent re-arm
        step(0, 1'b1, 1'b1);
        step(4, 1'b1, 1'b0); step(13, 1'b1, 1'b0);
        step(5, 1'b1, 1'b0); step(6, 1'b1, 1'b0);
        step(6, 1'b1, 1'b0); step(6, 1'b1, 1'b0);

        // 5: consumer stalled across 6 up-wraps, then drain
        step(0, 1'b1, 1'b1);
        step(11, 1'b0, 1'b0);
        for (int w = 0; w < 6; w++)
            for (int i = 0; i <= 11; i++) step(i, 1'b0, 1'b0);
        check("t5_ovf", int'(ev_ovf), 1);
        for (int k = 0; k < 6; k++) step(11, 1'b1, 1'b0);
        check("t5_drained", int'(ev_valid), 0);

        // full FIFO with simultaneous push and pop: nothing dropped
        step(0, 1'b1, 1'b1);
        step(11, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++)
            for (int i = 0; i <= 11; i++) step(i, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(0, 1'b1, 1'b0);

        // 6: saturation on the narrow instance, then async reset mid-stream
        step(0, 1'b1, 1'b1);
        step(11, 1'b1, 1'b0);
        for (int w = 0; w < 5; w++)
            for (int i = 0; i <= 11; i++) step(i, 1'b1, 1'b0);
        check("t6_sat", int'(s_up_wraps), 3);
        step(13, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0);
        reset = 1'b0;
        #2;
        check_all_zero("midreset");
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(11, 1'b1, 1'b0); step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0); step(0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
